// File: rtl/md_if.sv
// md_if: instruction/operand bundle between the execute stage and md_unit.
// The pipeline side uses the master modport, md_unit the slave modport.
interface md_if #(
    parameter int NB_DATA  = 32,
    parameter int NB_FUNCT = 6
);
    logic                i_valid;
    logic [NB_FUNCT-1:0] i_funct;
    logic                i_flush;
    logic [NB_DATA-1:0]  i_dato_a;
    logic [NB_DATA-1:0]  i_dato_b;
    logic [NB_DATA-1:0]  o_data;
    logic [NB_DATA-1:0]  o_hi;
    logic [NB_DATA-1:0]  o_lo;
    logic                o_busy;
    logic                o_stall;
    logic                o_done;

    modport master (
        output i_valid, i_funct, i_flush, i_dato_a, i_dato_b,
        input  o_data, o_hi, o_lo, o_busy, o_stall, o_done
    );

    modport slave (
        input  i_valid, i_funct, i_flush, i_dato_a, i_dato_b,
        output o_data, o_hi, o_lo, o_busy, o_stall, o_done
    );
endinterface

// File: rtl/md_unit.sv
// md_unit: iterative shift-add multiplier / restoring divider with HI/LO registers.
// Define MD_EARLY_OUT_EN to let multiplies finish once the remaining multiplier bits are zero.
module md_unit #(
    parameter int NB_DATA  = 32,
    parameter int NB_FUNCT = 6
) (
    input logic  i_clk,
    input logic  i_reset,
    md_if.slave  md
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam int CW = $clog2(NB_DATA) + 1;
    localparam logic [CW-1:0] LAST = CW'(NB_DATA - 1);

    localparam logic [NB_FUNCT-1:0] F_MFHI  = NB_FUNCT'(6'b010000);
    localparam logic [NB_FUNCT-1:0] F_MTHI  = NB_FUNCT'(6'b010001);
    localparam logic [NB_FUNCT-1:0] F_MFLO  = NB_FUNCT'(6'b010010);
    localparam logic [NB_FUNCT-1:0] F_MTLO  = NB_FUNCT'(6'b010011);
    localparam logic [NB_FUNCT-1:0] F_MULT  = NB_FUNCT'(6'b011000);
    localparam logic [NB_FUNCT-1:0] F_MULTU = NB_FUNCT'(6'b011001);
    localparam logic [NB_FUNCT-1:0] F_DIV   = NB_FUNCT'(6'b011010);
    localparam logic [NB_FUNCT-1:0] F_DIVU  = NB_FUNCT'(6'b011011);

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*NB_DATA-1:0] acc_q, acc_d;
    logic [NB_DATA-1:0]   opb_q, opb_d;
    logic [NB_DATA-1:0]   a_raw_q, a_raw_d;
    logic [NB_DATA-1:0]   hi_q, hi_d;
    logic [NB_DATA-1:0]   lo_q, lo_d;
    logic                 div_q, div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 bzero_q, bzero_d;
    logic                 done_q, done_d;

    logic                 f_mfhi, f_mthi, f_mflo, f_mtlo;
    logic                 f_mul, f_div, f_signed, f_md;
    logic                 idle, start;
    logic                 a_neg, b_neg;
    logic [NB_DATA-1:0]   abs_a, abs_b;
    logic [NB_DATA:0]     add_sum;
    logic [NB_DATA:0]     trial;
    logic [2*NB_DATA-1:0] mul_step, mul_next, div_step, prod_fix;
    logic [NB_DATA-1:0]   quo_fix, rem_fix;
    logic                 mul_last;

    assign f_mfhi   = md.i_funct == F_MFHI;
    assign f_mthi   = md.i_funct == F_MTHI;
    assign f_mflo   = md.i_funct == F_MFLO;
    assign f_mtlo   = md.i_funct == F_MTLO;
    assign f_mul    = md.i_funct == F_MULT || md.i_funct == F_MULTU;
    assign f_div    = md.i_funct == F_DIV || md.i_funct == F_DIVU;
    assign f_signed = md.i_funct == F_MULT || md.i_funct == F_DIV;
    assign f_md     = f_mul | f_div | f_mfhi | f_mthi | f_mflo | f_mtlo;

    assign idle  = state_q == IDLE;
    assign start = idle & md.i_valid & (f_mul | f_div) & !md.i_flush;
    assign a_neg = f_signed & md.i_dato_a[NB_DATA-1];
    assign b_neg = f_signed & md.i_dato_b[NB_DATA-1];
    assign abs_a = a_neg ? -md.i_dato_a : md.i_dato_a;
    assign abs_b = b_neg ? -md.i_dato_b : md.i_dato_b;

    // acc_q holds {partial product, unconsumed multiplier} or {remainder, quotient/dividend}
    assign add_sum  = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_step = {add_sum, acc_q[NB_DATA-1:1]};
    assign trial    = acc_q[2*NB_DATA-1:NB_DATA-1] - {1'b0, opb_q};
    assign div_step = trial[NB_DATA] ? {acc_q[2*NB_DATA-2:0], 1'b0}
                                     : {trial[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b1};

`ifdef MD_EARLY_OUT_EN
    logic [NB_DATA-1:0] rem_mask;
    assign rem_mask = {NB_DATA{1'b1}} >> (cnt_q + 1'b1);
    assign mul_last = (mul_step[NB_DATA-1:0] & rem_mask) == '0;
    assign mul_next = mul_step >> (LAST - cnt_q);
`else
    assign mul_last = cnt_q == LAST;
    assign mul_next = mul_step;
`endif

    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quo_fix  = neg_res_q ? -acc_q[NB_DATA-1:0] : acc_q[NB_DATA-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*NB_DATA-1:NB_DATA] : acc_q[2*NB_DATA-1:NB_DATA];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        a_raw_d   = a_raw_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
        done_d    = 1'b0;
        if (idle) begin
            if (start) begin
                state_d   = CALC;
                cnt_d     = '0;
                acc_d     = {{NB_DATA{1'b0}}, f_div ? abs_a : abs_b};
                opb_d     = f_div ? abs_b : abs_a;
                a_raw_d   = md.i_dato_a;
                div_d     = f_div;
                neg_res_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                bzero_d   = md.i_dato_b == '0;
            end else if (md.i_valid && !md.i_flush) begin
                hi_d = f_mthi ? md.i_dato_a : hi_q;
                lo_d = f_mtlo ? md.i_dato_a : lo_q;
            end
        end else if (md.i_flush) begin
            state_d = IDLE;
        end else if (state_q == CALC) begin
            cnt_d   = cnt_q + 1'b1;
            acc_d   = div_q ? div_step : mul_next;
            state_d = (div_q ? cnt_q == LAST : mul_last) ? FIX : CALC;
        end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            hi_d    = !div_q ? prod_fix[2*NB_DATA-1:NB_DATA] : bzero_q ? a_raw_q : rem_fix;
            lo_d    = !div_q ? prod_fix[NB_DATA-1:0] : bzero_q ? {NB_DATA{1'b1}} : quo_fix;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            a_raw_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            a_raw_q   <= a_raw_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
            done_q    <= done_d;
        end
    end

    assign md.o_data  = f_mfhi ? hi_q : f_mflo ? lo_q : '0;
    assign md.o_hi    = hi_q;
    assign md.o_lo    = lo_q;
    assign md.o_busy  = !idle;
    assign md.o_stall = !idle & md.i_valid & f_md;
    assign md.o_done  = done_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vector table for md_unit plus hand-written stall/flush/reset sequences.
module tb_md_unit;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs [12];

    md_if #(.NB_DATA(32), .NB_FUNCT(6)) mif ();
    md_unit #(.NB_DATA(32), .NB_FUNCT(6)) u_dut (.i_clk(clk), .i_reset(rst), .md(mif));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [5:0] f, input logic [31:0] b);
`ifdef MD_EARLY_OUT_EN
        logic [31:0] m;
        int s;
        if (f == F_MULT || f == F_MULTU) begin
            m = (f == F_MULT && b[31]) ? -b : b;
            s = 1;
            for (int i = 0; i < 32; i++) if (m[i]) s = i + 1;
            return s + 2;
        end
`endif
        return 34;
    endfunction

    // Presents the op for one cycle and returns the cycle index (accept cycle = 0) at which o_done is seen.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output int lat);
        mif.i_valid = 1'b1;
        mif.i_funct = f;
        mif.i_dato_a = a;
        mif.i_dato_b = b;
        step();
        mif.i_valid = 1'b0;
        mif.i_funct = '0;
        #1;
        lat = 1;
        while (!mif.o_done && lat < 100) begin
            step();
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int cyc;
        logic saw_done;
        vecs[0]  = '{F_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{F_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
        vecs[5]  = '{F_MULTU, 32'd5,        32'd1,        32'h00000000, 32'h00000005};
        vecs[6]  = '{F_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8]  = '{F_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vecs[9]  = '{F_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[10] = '{F_MULT,  32'h12345678, 32'd0,        32'h00000000, 32'h00000000};
        vecs[11] = '{F_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        mif.i_valid = 1'b0;
        mif.i_funct = '0;
        mif.i_flush = 1'b0;
        mif.i_dato_a = '0;
        mif.i_dato_b = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        mif.i_funct = F_MFHI;
        #1;
        chk("reset_hi", mif.o_hi, 32'h0);
        chk("reset_lo", mif.o_lo, 32'h0);
        chk("reset_busy", {31'h0, mif.o_busy}, 32'h0);
        chk("reset_done", {31'h0, mif.o_done}, 32'h0);
        chk("reset_data", mif.o_data, 32'h0);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d_latency", i), lat, exp_lat(vecs[i].f, vecs[i].b));
            chk($sformatf("v%0d_hi", i), mif.o_hi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), mif.o_lo, vecs[i].lo);
            mif.i_valid = 1'b1;
            mif.i_funct = F_MFHI;
            #1;
            chk($sformatf("v%0d_mfhi", i), mif.o_data, vecs[i].hi);
            mif.i_funct = F_MFLO;
            #1;
            chk($sformatf("v%0d_mflo", i), mif.o_data, vecs[i].lo);
            chk($sformatf("v%0d_mf_stall", i), {31'h0, mif.o_stall}, 32'h0);
            mif.i_valid = 1'b0;
            step();
            #1;
            chk($sformatf("v%0d_done_pulse", i), {31'h0, mif.o_done}, 32'h0);
            chk($sformatf("v%0d_idle", i), {31'h0, mif.o_busy}, 32'h0);
        end

        // MFLO held against a busy DIVU; ADD must not stall, a MULT must not be accepted
        mif.i_valid = 1'b1;
        mif.i_funct = F_DIVU;
        mif.i_dato_a = 32'd100;
        mif.i_dato_b = 32'd0;
        step();
        mif.i_valid = 1'b0;
        repeat (2) step();
        mif.i_valid = 1'b1;
        mif.i_funct = F_ADD;
        #1;
        chk("busy_add_nostall", {31'h0, mif.o_stall}, 32'h0);
        step();
        mif.i_funct = F_MULT;
        mif.i_dato_a = 32'd3;
        mif.i_dato_b = 32'd3;
        #1;
        chk("busy_mult_stall", {31'h0, mif.o_stall}, 32'h1);
        step();
        mif.i_funct = F_MFLO;
        #1;
        cyc = 5;
        while (!mif.o_done && cyc < 100) begin
            chk($sformatf("busy_mflo_stall_c%0d", cyc), {31'h0, mif.o_stall}, 32'h1);
            step();
            #1;
            cyc++;
        end
        chk("mflo_done_cycle", cyc, 34);
        chk("mflo_release_stall", {31'h0, mif.o_stall}, 32'h0);
        chk("mflo_data", mif.o_data, 32'hFFFFFFFF);
        chk("mflo_hi", mif.o_hi, 32'd100);
        mif.i_valid = 1'b0;
        step();

        // MTHI, then a MULT flushed in cycle 10
        mif.i_valid = 1'b1;
        mif.i_funct = F_MTHI;
        mif.i_dato_a = 32'h12345678;
        step();
        #1;
        chk("mthi_hi", mif.o_hi, 32'h12345678);
        mif.i_funct = F_MULT;
        mif.i_dato_a = 32'd5;
        mif.i_dato_b = 32'h40000000;
        step();
        mif.i_valid = 1'b0;
        repeat (9) step();
        #1;
        chk("flush_c10_busy", {31'h0, mif.o_busy}, 32'h1);
        mif.i_flush = 1'b1;
        step();
        mif.i_flush = 1'b0;
        #1;
        chk("flush_calc_busy", {31'h0, mif.o_busy}, 32'h0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            saw_done |= mif.o_done;
            step();
        end
        chk("flush_calc_nodone", {31'h0, saw_done}, 32'h0);
        chk("flush_calc_hi", mif.o_hi, 32'h12345678);
        chk("flush_calc_lo", mif.o_lo, 32'hFFFFFFFF);

        // flush wins over a valid op in IDLE
        mif.i_valid = 1'b1;
        mif.i_flush = 1'b1;
        mif.i_funct = F_MULT;
        step();
        #1;
        chk("flush_idle_nostart", {31'h0, mif.o_busy}, 32'h0);
        mif.i_funct = F_MTHI;
        mif.i_dato_a = 32'h0000DEAD;
        step();
        #1;
        chk("flush_idle_nomthi", mif.o_hi, 32'h12345678);
        mif.i_flush = 1'b0;

        // MTLO, then a DIV flushed while in FIX
        mif.i_funct = F_MTLO;
        mif.i_dato_a = 32'hA5A5A5A5;
        step();
        #1;
        chk("mtlo_lo", mif.o_lo, 32'hA5A5A5A5);
        mif.i_funct = F_DIV;
        mif.i_dato_a = 32'd100;
        mif.i_dato_b = 32'd7;
        step();
        mif.i_valid = 1'b0;
        repeat (32) step();
        #1;
        chk("fix_c33_busy", {31'h0, mif.o_busy}, 32'h1);
        mif.i_flush = 1'b1;
        step();
        mif.i_flush = 1'b0;
        #1;
        chk("flush_fix_done", {31'h0, mif.o_done}, 32'h0);
        chk("flush_fix_busy", {31'h0, mif.o_busy}, 32'h0);
        chk("flush_fix_hi", mif.o_hi, 32'h12345678);
        chk("flush_fix_lo", mif.o_lo, 32'hA5A5A5A5);

        // asynchronous reset in the middle of a multiply
        mif.i_valid = 1'b1;
        mif.i_funct = F_MULTU;
        mif.i_dato_a = 32'd3;
        mif.i_dato_b = 32'h80000000;
        step();
        mif.i_valid = 1'b0;
        repeat (5) step();
        #2;
        rst = 1'b1;
        #1;
        chk("areset_busy", {31'h0, mif.o_busy}, 32'h0);
        chk("areset_hi", mif.o_hi, 32'h0);
        chk("areset_lo", mif.o_lo, 32'h0);
        step();
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit with its own HI/LO register pair. It sits beside the execute-stage ALU and executes MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Uses a shift-add multiplier and a restoring divider, sequenced by a small FSM.
- Drives a stall request so the pipeline holds while an operation is in flight.

Parameters:
- NB_DATA, 32, operand/HI/LO width; must be even and >= 8.
- NB_FUNCT, 6, width of the funct code.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_valid  input  1  an instruction with a valid i_funct is present this cycle.
- i_funct  input  NB_FUNCT  funct code: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011; all other codes are ignored.
- i_flush  input  1  aborts any in-flight operation.
- i_dato_a  input  NB_DATA  rs operand (multiplicand / dividend / MTHI and MTLO source).
- i_dato_b  input  NB_DATA  rt operand (multiplier / divisor).
- o_data  output  NB_DATA  HI for MFHI, LO for MFLO, 0 otherwise; combinational.
- o_hi  output  NB_DATA  HI register.
- o_lo  output  NB_DATA  LO register.
- o_busy  output  1  high when state != IDLE.
- o_stall  output  1  high when o_busy & i_valid & (i_funct is any of the 8 codes above).
- o_done  output  1  one-cycle pulse when HI/LO take a MULT or DIV result.

Behaviour:
- Reset (async): state IDLE, HI = LO = 0, counter = 0, o_done = 0, o_busy = 0.
- FSM states:
  - IDLE, CALC, FIX.
  - IDLE -> CALC: i_valid & MULT/MULTU/DIV/DIVU & !i_flush (the accept edge). Latches operands, op type and signs; loads magnitudes (|a|, |b| for signed ops, raw values for unsigned); counter = 0.
  - CALC: one iteration per cycle for NB_DATA cycles, then -> FIX.
    - Multiply: 2*NB_DATA-bit product register, conditional add of multiplicand, shift right.
    - Divide: restoring step, shift remainder:quotient left, trial subtract.
  - FIX -> IDLE: applies the sign and writes HI/LO on this edge; o_done = 1 in the following cycle.
- Latency: accept edge E0; HI/LO updated at edge E0+NB_DATA+1; o_busy high for NB_DATA+1 cycles.
- Sign rules:
  - MULT: the 2*NB_DATA-bit product is negated if the operand signs differ. HI = upper half, LO = lower half.
  - DIV: the quotient is negated if the signs differ; the remainder takes the sign of the dividend.
  - DIVU/MULTU: no correction.
- DIV overflow, -2^(NB_DATA-1) / -1: LO = 0x80000000, HI = 0 (32-bit case).
- Divide by zero, all variants: LO = all ones, HI = i_dato_a as latched. This is a defined result, not an error.
- MTHI/MTLO: in IDLE with i_valid, HI or LO := i_dato_a at the next edge.
- MFHI/MFLO: o_data is valid combinationally in IDLE. While busy, o_stall is asserted and o_data shows stale HI/LO, which the pipeline discards.
- While busy, i_valid with any MD code raises o_stall and nothing is accepted. Non-MD codes are ignored and do not stall.
- i_flush:
  - In CALC or FIX: state -> IDLE at the next edge, HI/LO unchanged, no o_done.
  - With i_valid in IDLE: flush wins; nothing is accepted or written.
- Asynchronous reset in the middle of an operation returns to the reset values immediately.

Optional Feature:
- Macro MD_EARLY_OUT_EN.
- Defined: during a multiply in CALC, if the remaining unshifted multiplier bits are all zero, the FSM jumps to FIX on the next edge with the product register already aligned.
  - Multiply latency becomes variable: minimum 2 cycles (multiplier 0 or 1), maximum NB_DATA+1.
  - Divide latency is unchanged.
- Undefined: fixed latency for all operations. The early-out logic is absent.

Test Plan:
- MULT a=-3 (0xFFFFFFFD), b=7 -> o_done pulses 34 cycles after the accept cycle; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then MFHI/MFLO return these values on o_data.
- DIV a=-7, b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIV a=0x80000000, b=-1 -> LO=0x80000000, HI=0.
- DIVU a=100, b=0 -> LO=0xFFFFFFFF, HI=100. Also: MFLO presented on cycle 5 of the operation -> o_stall=1 until the cycle o_done=1, then o_data=0xFFFFFFFF.
- MTHI 0x12345678, then MULT started and i_flush asserted on cycle 10 -> o_busy drops next cycle, no o_done, HI still 0x12345678.
- MD_EARLY_OUT_EN defined, MULTU a=5, b=1 -> o_done within 3 cycles of accept, LO=5, HI=0. Undefined -> o_done at cycle 34.
